aes_axil_regs: RTL

AES_AXIL_REGS -- requirements
Module: aes_axil_regs

---
 rtl/aes_ip_pkg.sv | 10 +
 rtl/aes_axil_wr_fsm.sv | 64 ++++++
 rtl/aes_axil_regs.sv | 109 ++++++++++
 3 files changed

// File: rtl/aes_ip_pkg.sv
// aes_ip_pkg: shared register offsets, response code and FSM state types
// for the AES AXI4-Lite register block.
package aes_ip_pkg;
    localparam logic [7:0] ADDR_DATA0  = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h10;
    localparam logic [7:0] ADDR_STATUS = 8'h14;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/aes_axil_wr_fsm.sv
// aes_axil_wr_fsm: AXI4-Lite write channel; holds AW and W independently and
// issues a single register write once both halves of the transaction are held.
module aes_axil_wr_fsm
    import aes_ip_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_live,
    input  logic [AW-1:0]   i_awaddr,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic            o_bvalid,
    input  logic            i_bready,
    output logic            o_wr_en,
    output logic [AW-1:0]   o_wr_addr,
    output logic [DW-1:0]   o_wr_data,
    output logic [DW/8-1:0] o_wr_strb
);
    wr_state_t       r_state, w_next;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [DW/8-1:0] r_strb;
    logic            w_aw_hs, w_w_hs;

    assign o_awready = i_live && (r_state == W_IDLE || r_state == W_WAIT_ADDR);
    assign o_wready  = i_live && (r_state == W_IDLE || r_state == W_WAIT_DATA);
    assign o_bvalid  = r_state == W_RESP;
    assign w_aw_hs   = i_awvalid && o_awready;
    assign w_w_hs    = i_wvalid && o_wready;
    // Whichever channel lands last completes the pair; take its value live, the other from the hold register.
    assign o_wr_en   = (w_aw_hs || r_state == W_WAIT_DATA) && (w_w_hs || r_state == W_WAIT_ADDR);
    assign o_wr_addr = w_aw_hs ? i_awaddr : r_addr;
    assign o_wr_data = w_w_hs ? i_wdata : r_data;
    assign o_wr_strb = w_w_hs ? i_wstrb : r_strb;

    always_comb begin
        w_next = r_state;
        if (o_wr_en) w_next = W_RESP;
        else if (r_state == W_RESP && i_bready) w_next = W_IDLE;
        else if (w_aw_hs) w_next = W_WAIT_DATA;
        else if (w_w_hs) w_next = W_WAIT_ADDR;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= W_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_strb  <= '0;
        end else begin
            r_state <= w_next;
            if (w_aw_hs) r_addr <= i_awaddr;
            if (w_w_hs) r_data <= i_wdata;
            if (w_w_hs) r_strb <= i_wstrb;
        end
    end
endmodule

// File: rtl/aes_axil_regs.sv
// aes_axil_regs: AXI4-Lite register front end for the AES core: four data
// words, a start strobe and a status word with a sticky done flag.
module aes_axil_regs
    import aes_ip_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    aes_data_o,
    output logic                            aes_start_o,
    input  logic                            aes_busy_i,
    input  logic                            aes_done_i
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] A_DATA0  = AW'(ADDR_DATA0);
    localparam logic [AW-1:0] A_CTRL   = AW'(ADDR_CTRL);
    localparam logic [AW-1:0] A_STATUS = AW'(ADDR_STATUS);
    localparam logic [AW-1:0] A_DMASK  = ~AW'(12);

    rd_state_t       r_rstate, w_rnext;
    logic [DW-1:0]   r_data [4];
    logic [DW-1:0]   r_rdata, w_rd;
    logic            r_live, r_done, r_start;
    logic            w_wr_en, w_wr_dsel, w_rd_dsel, w_ar_hs, w_unused;
    logic [AW-1:0]   w_wr_addr, w_wa, w_ra;
    logic [DW-1:0]   w_wr_data;
    logic [DW/8-1:0] w_wr_strb;

    aes_axil_wr_fsm #(.AW(AW), .DW(DW)) u_wr (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_live    (r_live),
        .i_awaddr  (S_AXI_AWADDR),
        .i_awvalid (S_AXI_AWVALID),
        .o_awready (S_AXI_AWREADY),
        .i_wdata   (S_AXI_WDATA),
        .i_wstrb   (S_AXI_WSTRB),
        .i_wvalid  (S_AXI_WVALID),
        .o_wready  (S_AXI_WREADY),
        .o_bvalid  (S_AXI_BVALID),
        .i_bready  (S_AXI_BREADY),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb)
    );

    assign w_unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], w_wr_addr[1:0]};
    assign w_wa          = {w_wr_addr[AW-1:2], 2'b00};
    assign w_ra          = {S_AXI_ARADDR[AW-1:2], 2'b00};
    assign w_wr_dsel     = (w_wa & A_DMASK) == A_DATA0;
    assign w_rd_dsel     = (w_ra & A_DMASK) == A_DATA0;
    assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign S_AXI_ARREADY = r_live && r_rstate == R_IDLE;
    assign S_AXI_RVALID  = r_rstate == R_DATA;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign aes_data_o    = {r_data[3], r_data[2], r_data[1], r_data[0]};
    assign aes_start_o   = r_start;

    always_comb begin
        w_rnext = w_ar_hs ? R_DATA : (S_AXI_RVALID && S_AXI_RREADY) ? R_IDLE : r_rstate;
        w_rd    = w_rd_dsel ? r_data[w_ra[3:2]] :
                  (w_ra == A_STATUS) ? {{(DW-2){1'b0}}, r_done, aes_busy_i} : '0;
    end

    // r_live keeps the ready outputs low until the first cycle after reset is released.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_live   <= 1'b0;
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_start  <= 1'b0;
            r_data   <= '{default: '0};
        end else begin
            r_live   <= 1'b1;
            r_rstate <= w_rnext;
            if (w_ar_hs) r_rdata <= w_rd;
            r_done   <= aes_done_i || (r_done && !(w_ar_hs && w_ra == A_STATUS));
            r_start  <= w_wr_en && w_wa == A_CTRL && w_wr_data[0] && w_wr_strb[0];
            for (int b = 0; b < DW/8; b++)
                if (w_wr_en && w_wr_dsel && w_wr_strb[b]) r_data[w_wa[3:2]][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end
endmodule
